// File: rtl/mul16_seq.sv
// mul16_seq: 16x16 unsigned shift-and-add multiplier, one partial product per RUN cycle.
// Define MUL16_SEQ_EARLY_EXIT_EN to end RUN as soon as no multiplier bits remain.
module mul16_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;
    logic [31:0] mcand, acc, acc_sum;
    logic [15:0] mplier;
    logic [3:0]  count;
    logic        last;
    assign acc_sum = mplier[0] ? acc + mcand : acc;
`ifdef MUL16_SEQ_EARLY_EXIT_EN
    assign last = (count == 4'd15) || (mplier[15:1] == 15'd0);
`else
    assign last = count == 4'd15;
`endif
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = start ? RUN : IDLE;
            default: next = IDLE;
        endcase
    end
    // Result registers only change on the last RUN cycle, so a new start leaves them intact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            out    <= '0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
            if (last) begin
                out <= acc_sum[15:0];
                ovf <= |acc_sum[31:16];
            end
        end else if (start) begin
            mcand  <= {16'd0, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end
    end
endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 Parameters: none; all datapath widths are fixed at 16-bit operands and a 32-bit internal product.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on rising edge.
REQ-005 a  input  16  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 b  input  16  multiplier, unsigned; sampled only when start is accepted.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse, high only in DONE.
REQ-009 out  output  16  registered low 16 bits of a*b.
REQ-010 ovf  output  1  registered flag, high when the upper 16 bits of the 32-bit product are nonzero.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 start=1 in IDLE or DONE SHALL be accepted: mcand<=zero-extended a (32b), mplier<=b, acc<=0, count<=0, next state RUN.
REQ-013 start in RUN SHALL be ignored, with no effect on any register.
REQ-014 Each RUN cycle: if mplier[0]=1 then acc<=acc+mcand, modulo 2^32; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-015 Without early exit, RUN SHALL last exactly 16 cycles, then the FSM SHALL go to DONE.
REQ-016 On the RUN->DONE transition: out<=final acc[15:0]; ovf<=|final acc[31:16].
REQ-017 "Final acc" SHALL include the last RUN cycle's addition.
REQ-018 DONE SHALL last one cycle, then go to IDLE unless start is accepted per REQ-012.
REQ-019 out and ovf SHALL hold their value from the last DONE entry until the next DONE entry; accepting a new start SHALL NOT alter them.
REQ-020 Latency: start accepted at edge k -> busy high in cycles k+1..k+16 -> done high in cycle k+17.
REQ-021 Back-to-back: start=1 during DONE SHALL make busy high in the very next cycle, with no IDLE gap.
REQ-022 busy and done SHALL be decoded directly from state registers, with no combinational path from start.
REQ-023 a and b changing outside the acceptance edge SHALL have no effect on the result.

Reset
REQ-024 reset=1 SHALL immediately force: state=IDLE, busy=0, done=0, out=0x0000, ovf=0, acc=0, mcand=0, mplier=0, count=0.
REQ-025 reset asserted mid-RUN SHALL abort the operation; no done pulse follows and out/ovf read 0.
REQ-026 After reset deasserts, the first start SHALL behave as from power-up.

Configuration
REQ-027 Macro MUL16_SEQ_EARLY_EXIT_EN.
REQ-028 When the macro is defined, RUN SHALL end after the current cycle when the shifted mplier becomes 0.
REQ-029 With the macro, the number of RUN cycles SHALL be max(1, index of highest set bit of b + 1); the result is identical to the non-early-exit result.
REQ-030 When the macro is not defined, RUN SHALL always last 16 cycles, regardless of b.

Verification
REQ-031 a=3, b=5, start at edge k -> done in cycle k+17; out=0x000F, ovf=0; busy high for exactly 16 cycles.
REQ-032 a=0xFFFF, b=0xFFFF -> out=0x0001, ovf=1; a=0x0100, b=0x0100 -> out=0x0000, ovf=1.
REQ-033 start pulsed again at cycle k+5 with a=7, b=7 -> ignored; out=0x000F at done; a second start in the DONE cycle -> busy high next cycle.
REQ-034 reset asserted in cycle k+8 of a=0x1234, b=0x0002 run -> IDLE at once, no done pulse, out=0, ovf=0.
REQ-035 With MUL16_SEQ_EARLY_EXIT_EN: b=0x0001, a=0x00AB -> done in cycle k+2, out=0x00AB; b=0 -> done in cycle k+2, out=0; b=0x8000, a=2 -> done in cycle k+17, out=0, ovf=1.
